// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors, the bubble instruction
// and the fetch state encoding.
package cpu_defs;

    localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;
    localparam logic [31:0] INST_NOP   = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction SRAM port: the fetch stage is the master, the memory the slave.
interface inst_fetch_if;

    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        output inst_sram_rdata
    );

endinterface

// File: rtl/inst_fetch_hold_buf.sv
// One-entry buffer that keeps the instruction decode stalled on, so the SRAM
// output may change while decode waits.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] din,
    output logic        hold_valid,
    output logic [31:0] hold_inst
);

    // NOTE: hold_inst is reset along with hold_valid so id_inst never shows X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_inst  <= '0;
        end else if (flush || drain) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_inst  <= din;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the instruction SRAM from the PC register,
// selects the next PC and presents one fetch slot to decode.
module inst_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] INST_NOP = cpu_defs::INST_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_q,
    output logic [31:0]        pc_d,
    output logic               pc_en,
    inst_fetch_if.master       sram,
    input  logic               id_stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               exc_req,
    input  logic [31:0]        exc_target,
    output logic [31:0]        id_inst,
    output logic [31:0]        id_pc,
    output logic               id_valid,
    output logic               id_adel
);

    fetch_state_e state, state_next;
    logic         f_valid, f_adel;
    logic [31:0]  f_pc;
    logic         misaligned, kill_next;
    logic         capture, drain;
    logic         hold_valid;
    logic [31:0]  hold_inst;

    assign misaligned          = is_misaligned(pc_q);
    assign sram.inst_sram_addr = pc_q;
    assign sram.inst_sram_wen  = 4'b0000;
    assign sram.inst_sram_en   = !rst && !misaligned && (state == RUN || exc_req);

    assign id_inst  = hold_valid ? hold_inst
                    : ((f_adel || !f_valid) ? INST_NOP : sram.inst_sram_rdata);
    assign id_pc    = f_pc;
    assign id_valid = f_valid && !exc_req;
    assign id_adel  = f_adel && f_valid && !exc_req;

    // Redirects kill the sequential fetch already in flight; the branch delay slot survives.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_d      = pc_q + 32'd4;
        pc_en     = 1'b1;
        kill_next = 1'b0;
        if (exc_req) begin
            pc_d      = exc_target;
            kill_next = 1'b1;
        end else if (id_stall) begin
            pc_en     = 1'b0;
        end else if (br_taken) begin
            pc_d      = br_target;
            kill_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        drain      = 1'b0;
        case (state)
            RUN: begin
                if (id_stall && f_valid && !exc_req) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (exc_req) begin
                    state_next = RUN;
                end else if (!id_stall) begin
                    state_next = RUN;
                    drain      = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            f_valid <= 1'b0;
            f_pc    <= RESET_PC;
            f_adel  <= 1'b0;
        end else begin
            state <= state_next;
            if (pc_en) begin
                f_pc    <= pc_q;
                f_adel  <= misaligned;
                f_valid <= !kill_next;
            end
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .drain      (drain),
        .flush      (exc_req),
        .din        (id_inst),
        .hold_valid (hold_valid),
        .hold_inst  (hold_inst)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, all checked
// against a slot-level model where decode must always see mem[pc] for its slot.
module tb_inst_fetch;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q, pc_d, br_target, exc_target, id_inst, id_pc;
    logic        pc_en, id_stall, br_taken, exc_req, id_valid, id_adel;
    logic [31:0] sram_q, garbage_word;
    logic        garbage;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: next fetch address, the slot shown to decode, and
    // whether decode was already stalled on that valid slot last cycle.
    logic [31:0] m_fetch, m_pc;
    logic        m_valid, m_adel, m_holding;

    always #5 clk = ~clk;

    inst_fetch_if sram ();

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_q       (pc_q),
        .pc_d       (pc_d),
        .pc_en      (pc_en),
        .sram       (sram),
        .id_stall   (id_stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .exc_target (exc_target),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_valid   (id_valid),
        .id_adel    (id_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // PC register and a synchronous SRAM whose output holds when not enabled.
    assign sram.inst_sram_rdata = garbage ? garbage_word : sram_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            sram_q <= '0;
        end else begin
            if (pc_en) pc_q <= pc_d;
            if (sram.inst_sram_en) sram_q <= mem_word(sram.inst_sram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_fetch   = RESET_PC;
        m_pc      = RESET_PC;
        m_valid   = 1'b0;
        m_adel    = 1'b0;
        m_holding = 1'b0;
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                         input logic ex, input logic [31:0] et);
        id_stall     = st;
        br_taken     = br;
        br_target    = bt;
        exc_req      = ex;
        exc_target   = et;
        garbage      = m_holding;
        garbage_word = $urandom;
        #1;
    endtask

    task automatic verify();
        logic [31:0] exp_pc_d;
        logic        exp_pc_en;
        if (exc_req) begin
            exp_pc_d = exc_target;   exp_pc_en = 1'b1;
        end else if (id_stall) begin
            exp_pc_d = m_fetch + 4;  exp_pc_en = 1'b0;
        end else if (br_taken) begin
            exp_pc_d = br_target;    exp_pc_en = 1'b1;
        end else begin
            exp_pc_d = m_fetch + 4;  exp_pc_en = 1'b1;
        end
        check("sram_addr", sram.inst_sram_addr, m_fetch);
        check("sram_en", 32'(sram.inst_sram_en),
              32'((m_fetch[1:0] == 2'b00) && (!m_holding || exc_req)));
        check("sram_wen", 32'(sram.inst_sram_wen), 32'd0);
        check("pc_d", pc_d, exp_pc_d);
        check("pc_en", 32'(pc_en), 32'(exp_pc_en));
        check("id_pc", id_pc, m_pc);
        check("id_valid", 32'(id_valid), 32'(m_valid && !exc_req));
        check("id_adel", 32'(id_adel), 32'(m_valid && m_adel && !exc_req));
        check("id_inst", id_inst, (m_valid && !m_adel) ? mem_word(m_pc) : INST_NOP);
    endtask

    task automatic tick();
        if (exc_req) begin
            m_pc      = m_fetch;
            m_adel    = (m_fetch[1:0] != 2'b00);
            m_valid   = 1'b0;
            m_fetch   = exc_target;
            m_holding = 1'b0;
        end else if (id_stall) begin
            m_holding = m_valid;
        end else begin
            m_pc      = m_fetch;
            m_adel    = (m_fetch[1:0] != 2'b00);
            m_valid   = !br_taken;
            m_fetch   = br_taken ? br_target : m_fetch + 4;
            m_holding = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input logic st, input logic br, input logic [31:0] bt,
                       input logic ex, input logic [31:0] et);
        drive(st, br, bt, ex, et);
        verify();
        tick();
    endtask

    initial begin
        logic        st, br, ex;
        logic [31:0] bt, et;

        rst = 1'b0;
        id_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        exc_req = 1'b0; exc_target = '0;
        garbage = 1'b0; garbage_word = '0;
        model_reset();
        #1 rst = 1'b1;

        // Outputs held in reset
        @(negedge clk);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_adel", 32'(id_adel), 32'd0);
        check("rst_inst", id_inst, INST_NOP);
        check("rst_pc", id_pc, RESET_PC);
        check("rst_sram_en", 32'(sram.inst_sram_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch from the reset vector
        drive(0, 0, 0, 0, 0);
        check("t1_addr", sram.inst_sram_addr, 32'hbfc0_0000);
        verify(); tick();
        drive(0, 0, 0, 0, 0);
        check("t1_pc", id_pc, 32'hbfc0_0000);
        check("t1_valid", 32'(id_valid), 32'd1);
        verify(); tick();
        cyc(0, 0, 0, 0, 0);

        // Three-cycle decode stall on bfc00008, SRAM output garbled while held
        drive(1, 0, 0, 0, 0);
        check("t2_pc", id_pc, 32'hbfc0_0008);
        verify(); tick();
        repeat (2) begin
            drive(1, 0, 0, 0, 0);
            check("t2_pc_en", 32'(pc_en), 32'd0);
            check("t2_sram_en", 32'(sram.inst_sram_en), 32'd0);
            check("t2_held", id_inst, mem_word(32'hbfc0_0008));
            verify(); tick();
        end
        drive(0, 0, 0, 0, 0);
        check("t2_release", id_pc, 32'hbfc0_0008);
        verify(); tick();
        drive(0, 0, 0, 0, 0);
        check("t2_next", id_pc, 32'hbfc0_000c);
        verify(); tick();
        cyc(0, 0, 0, 0, 0);

        // Branch in decode while the delay slot is presented
        drive(0, 1, 32'hbfc0_0100, 0, 0);
        check("t3_slot", id_pc, 32'hbfc0_0014);
        verify(); tick();
        drive(0, 0, 0, 0, 0);
        check("t3_bubble", 32'(id_valid), 32'd0);
        verify(); tick();

        // Exception raised while holding
        drive(1, 0, 0, 0, 0);
        check("t3_target", id_pc, 32'hbfc0_0100);
        check("t3_valid", 32'(id_valid), 32'd1);
        verify(); tick();
        drive(1, 0, 0, 1, EXC_VECTOR);
        check("t4_valid", 32'(id_valid), 32'd0);
        check("t4_pc_en", 32'(pc_en), 32'd1);
        verify(); tick();
        cyc(0, 0, 0, 0, 0);

        // Misaligned branch target
        drive(0, 1, 32'hbfc0_0102, 0, 0);
        check("t4_pc", id_pc, EXC_VECTOR);
        check("t4_inst", id_inst, mem_word(EXC_VECTOR));
        verify(); tick();
        cyc(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t5_adel", 32'(id_adel), 32'd1);
        check("t5_valid", 32'(id_valid), 32'd1);
        check("t5_inst", id_inst, 32'd0);
        verify(); tick();
        cyc(0, 0, 0, 1, EXC_VECTOR);
        cyc(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a hold
        cyc(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        verify();
        #2 rst = 1'b1;
        #1;
        check("t6_valid", 32'(id_valid), 32'd0);
        check("t6_pc", id_pc, RESET_PC);
        check("t6_inst", id_inst, INST_NOP);
        model_reset();
        id_stall = 1'b0;
        garbage  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("t6_addr", sram.inst_sram_addr, RESET_PC);
        verify(); tick();
        drive(0, 0, 0, 0, 0);
        check("t6_restart", id_pc, RESET_PC);
        verify(); tick();

        // Random traffic
        repeat (400) begin
            st = ($urandom % 100) < 30;
            br = ($urandom % 100) < 12;
            ex = ($urandom % 100) < 5;
            bt = 32'hbfc0_0000 | ($urandom & 32'h0000_fffc);
            et = 32'hbfc0_0000 | ($urandom & 32'h0000_fffc);
            if ($urandom % 8 == 0) bt = bt | 32'd2;
            if ($urandom % 10 == 0) et = et | 32'd1;
            cyc(st, br, bt, ex, et);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
